counter_universal: RTL and testbench
====================================

# counter_universal

Parametrised successor to the fixed-function forward/backward counters. Combines up/down counting, a programmable limit (modulus − 1), programmable step, synchronous load and three end-of-range modes (wrap, saturate, one-shot) in one block. It provides a carry/borrow pulse for cascading and a one-shot FSM for timer use. It sits in the shared utils library beside the existing counters and is the counter instantiated by new designs.

## Interface
- WORD_WIDTH, 8, width of value, limit, step and load operands (≥ 2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; one step per cycle while high
- dir  in  1  1 = up, 0 = down
- mode  in  2  0 = WRAP, 1 = SATURATE, 2 = ONE_SHOT, 3 = reserved (treated as HOLD: no counting)
- load  in  1  synchronous load of load_value
- load_value  in  WORD_WIDTH  value to load
- limit  in  WORD_WIDTH  highest legal count; range is 0..limit
- step  in  WORD_WIDTH  increment/decrement; 0 = hold; legal range 0..limit+1
- start  in  1  one-shot arm/restart pulse
- value  out  WORD_WIDTH  registered count
- carry  out  1  registered 1-cycle pulse on wrap (up) or borrow (down)
- at_limit  out  1  combinational: value == limit
- at_zero  out  1  combinational: value == 0
- busy  out  1  one-shot FSM in RUN
- done  out  1  one-shot FSM in DONE (level)

## Operation
- Priority per cycle: reset > load > start > count.
- load: value ← min(load_value, limit). carry ← 0. FSM → IDLE.
- Count arithmetic uses WORD_WIDTH+1 bits; no intermediate overflow.
- Up, WRAP: if value+step > limit, value ← value+step−(limit+1) and carry=1; otherwise value ← value+step.
- Down, WRAP: if value < step, value ← value+(limit+1)−step and carry=1; otherwise value ← value−step.
- SATURATE: clamps at limit (up) or 0 (down). carry stays 0.
- ONE_SHOT FSM, states IDLE, RUN, DONE:
  - IDLE: holds value. start → RUN.
  - RUN: counts saturating while en is high. When the next value equals limit (up) or 0 (down) → DONE in the same edge.
  - DONE: holds value. start → RUN. start in RUN is ignored.
  - start from IDLE/DONE while already at the terminal value → DONE next cycle, value unchanged.
- In WRAP/SATURATE/HOLD the FSM is forced to IDLE; start is ignored; busy = done = 0.
- limit = 0: value stays 0. WRAP with step = 1 pulses carry every enabled cycle.
- step > limit+1: out of contract. The bench does not check this case.
- Reset values: value = 0, carry = 0, FSM = IDLE (busy = 0, done = 0). at_zero = 1; at_limit = (limit == 0).

## Timing
- Latency: value, carry, busy and done update on the rising edge after the qualifying inputs. at_limit and at_zero follow value combinationally.
- All inputs are sampled on the rising clk edge.
- A mode, dir, limit or step change takes effect on the next edge. No pipeline state is kept.
- If a limit change leaves value > limit, the next enabled count first clamps value to limit and applies no step. carry stays 0 on that edge.
- Reset asserted mid-count clears all state immediately, independent of clk. The first count after deassertion occurs on the first edge with en = 1.
- carry is never asserted for two edges unless a wrap occurs on each.

## Structure
- Package counter_pkg holds:
  - the mode enum: CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_HOLD
  - the one-shot state enum: OS_IDLE, OS_RUN, OS_DONE
- Sub-module counter_step_unit: combinational. Takes value, step, limit, dir and a saturate flag. Returns next value and the wrap flag, using WORD_WIDTH+1 arithmetic.
- counter_universal holds the registers, the load/priority logic and the FSM.
- A task wrapper, task_counter_universal, is added alongside the existing counter tasks.

## Test plan
- WORD_WIDTH=8, WRAP, up, limit=9, step=3, en held from reset → value 0,3,6,9,2,5,8,1. carry high only on the edges producing 2 and 1.
- WRAP, down, limit=9, step=4, load 1 → value 7 with carry=1, then 3, then 9 with carry=1.
- SATURATE, up, limit=200, step=50, load 120 → 170, 200, 200. carry always 0. at_limit=1 from the first 200.
- ONE_SHOT, up, limit=5, step=1, load 2:
  - start → busy next cycle; value 3,4,5; done=1 on the edge value reaches 5; holds 5.
  - A second start with value=5 → DONE again next cycle.
- load during RUN: load_value=250, limit=100 → value=100, FSM IDLE, carry=0. Simultaneous start and load → load wins.
- Assert reset asynchronously mid-count at value 7 → value=0, done=0, carry=0 before the next clk edge. at_zero=1.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types for the universal up/down counter: end-of-range
//            mode encoding and one-shot FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // End-of-range behaviour selected by the 2-bit mode input
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2,
    CNT_HOLD    = 2'd3
  } cnt_mode_e;

  // One-shot timer FSM states
  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_step_unit.sv
`default_nettype none
// ============================================================================
// Module   : counter_step_unit
// Purpose  : Combinational next-count calculation for the universal counter.
//            Applies one up/down step inside the range 0..limit, either
//            wrapping (with a wrap flag) or clamping at the range ends.
// Revision : 1.0 - initial release
// ============================================================================
module counter_step_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] value,
  input  logic [WORD_WIDTH-1:0] step,
  input  logic [WORD_WIDTH-1:0] limit,
  input  logic                  dir,
  input  logic                  saturate,
  output logic [WORD_WIDTH-1:0] next_value,
  output logic                  wrap
);

  // One extra bit keeps value+step from overflowing before the range test
  logic [WORD_WIDTH:0]   w_sum;
  logic [WORD_WIDTH-1:0] w_up_wrapped;
  logic [WORD_WIDTH-1:0] w_dn_wrapped;

  assign w_sum = {1'b0, value} + {1'b0, step};

  // The wrapped results always land inside 0..limit, so modulo-2^W
  // arithmetic on W bits yields the exact value.
  assign w_up_wrapped = value + step - limit - 1'b1;
  assign w_dn_wrapped = value - step + limit + 1'b1;

  // Select the stepped, wrapped or clamped result
  always_comb begin
    next_value = value;
    wrap       = 1'b0;
    if (dir) begin
      if (w_sum > {1'b0, limit}) begin
        if (saturate) begin
          next_value = limit;
        end else begin
          next_value = w_up_wrapped;
          wrap       = 1'b1;
        end
      end else begin
        next_value = w_sum[WORD_WIDTH-1:0];
      end
    end else begin
      if (value < step) begin
        if (saturate) begin
          next_value = '0;
        end else begin
          next_value = w_dn_wrapped;
          wrap       = 1'b1;
        end
      end else begin
        next_value = value - step;
      end
    end
  end

endmodule : counter_step_unit
`default_nettype wire

// File: rtl/counter_universal.sv
`default_nettype none
// ============================================================================
// Module   : counter_universal
// Purpose  : Up/down counter with programmable limit and step, synchronous
//            load, wrap / saturate / one-shot end-of-range modes, a carry
//            pulse for cascading and a one-shot timer FSM.
// Revision : 1.0 - initial release
// ============================================================================
module counter_universal
  import counter_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_value,
  input  logic [WORD_WIDTH-1:0] limit,
  input  logic [WORD_WIDTH-1:0] step,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] value,
  output logic                  carry,
  output logic                  at_limit,
  output logic                  at_zero,
  output logic                  busy,
  output logic                  done
);

  cnt_mode_e             w_mode;
  logic [WORD_WIDTH-1:0] w_step_next;
  logic                  w_step_wrap;
  logic [WORD_WIDTH-1:0] w_count_val;
  logic [WORD_WIDTH-1:0] w_load_val;
  logic [WORD_WIDTH-1:0] w_terminal;
  logic                  w_over;

  logic [WORD_WIDTH-1:0] r_value;
  logic                  r_carry;
  os_state_e             r_state;
  logic                  r_busy;
  logic                  r_done;

  assign w_mode = cnt_mode_e'(mode);

  counter_step_unit #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_step (
    .value      (r_value),
    .step       (step),
    .limit      (limit),
    .dir        (dir),
    .saturate   (w_mode != CNT_WRAP),
    .next_value (w_step_next),
    .wrap       (w_step_wrap)
  );

  // A value left above a freshly lowered limit is clamped before stepping
  assign w_over      = (r_value > limit);
  assign w_count_val = w_over ? limit : w_step_next;
  assign w_load_val  = (load_value > limit) ? limit : load_value;
  assign w_terminal  = dir ? limit : '0;

  // Count register, carry pulse and one-shot FSM; priority load > start > count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_carry <= 1'b0;
      r_state <= OS_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (load) begin
        r_value <= w_load_val;
        r_state <= OS_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_mode != CNT_ONESHOT) begin
        r_state <= OS_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        if (en && (w_mode != CNT_HOLD)) begin
          r_value <= w_count_val;
          r_carry <= w_step_wrap && !w_over;
        end
      end else begin
        case (r_state)
          OS_IDLE, OS_DONE: begin
            if (start) begin
              if (r_value == w_terminal) begin
                r_state <= OS_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= OS_RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end
            end
          end
          OS_RUN: begin
            if (en) begin
              r_value <= w_count_val;
              if (w_count_val == w_terminal) begin
                r_state <= OS_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= OS_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value    = r_value;
  assign carry    = r_carry;
  assign busy     = r_busy;
  assign done     = r_done;
  assign at_limit = (r_value == limit);
  assign at_zero  = (r_value == '0);

endmodule : counter_universal
`default_nettype wire

// File: tb/tb_counter_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_universal
// Purpose  : Self-checking bench for counter_universal: directed vector table,
//            asynchronous reset sequence and randomized run against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_universal;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] limit;
  logic [7:0] step;
  logic       start;
  logic [7:0] value;
  logic       carry;
  logic       at_limit;
  logic       at_zero;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  counter_universal #(
    .WORD_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .dir        (dir),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .step       (step),
    .start      (start),
    .value      (value),
    .carry      (carry),
    .at_limit   (at_limit),
    .at_zero    (at_zero),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic [7:0] lim;
    logic [7:0] st;
    logic       dr;
    logic [1:0] md;
    logic       e;
    logic       s;
    logic [7:0] ev;
    logic       ec;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input int lv, input int lim, input int st,
                              input logic dr, input int md, input logic e, input logic s,
                              input int ev, input logic ec, input logic eb, input logic ed);
    vec_t v;
    v.ld = ld; v.lv = 8'(lv); v.lim = 8'(lim); v.st = 8'(st);
    v.dr = dr; v.md = 2'(md); v.e = e; v.s = s;
    v.ev = 8'(ev); v.ec = ec; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ev, input int ec, input int eb,
                         input int ed, input int lim);
    chk({tag, " value"},    int'(value),    ev);
    chk({tag, " carry"},    int'(carry),    ec);
    chk({tag, " busy"},     int'(busy),     eb);
    chk({tag, " done"},     int'(done),     ed);
    chk({tag, " at_limit"}, int'(at_limit), (ev == lim) ? 1 : 0);
    chk({tag, " at_zero"},  int'(at_zero),  (ev == 0) ? 1 : 0);
  endtask

  // Behavioural model state
  int m_v;
  int m_c;
  int m_run;
  int m_done;

  task automatic model_count(input int lim, input int st, input int wrap_mode);
    int t;
    if (m_v > lim) begin
      m_v = lim;
    end else if (dir) begin
      t = m_v + st;
      if (t > lim) begin
        if (wrap_mode != 0) begin m_v = t - (lim + 1); m_c = 1; end
        else m_v = lim;
      end else m_v = t;
    end else begin
      if (m_v < st) begin
        if (wrap_mode != 0) begin m_v = m_v + (lim + 1) - st; m_c = 1; end
        else m_v = 0;
      end else m_v = m_v - st;
    end
  endtask

  task automatic model_edge();
    int lim;
    int st;
    int term;
    lim  = int'(limit);
    st   = int'(step);
    term = dir ? lim : 0;
    m_c  = 0;
    if (load) begin
      m_v = (int'(load_value) > lim) ? lim : int'(load_value);
      m_run = 0; m_done = 0;
    end else if (mode != 2'd2) begin
      m_run = 0; m_done = 0;
      if (en && mode != 2'd3) model_count(lim, st, (mode == 2'd0) ? 1 : 0);
    end else if (m_run != 0) begin
      if (en) begin
        model_count(lim, st, 0);
        if (m_v == term) begin m_run = 0; m_done = 1; end
      end
    end else if (start) begin
      if (m_v == term) begin m_run = 0; m_done = 1; end
      else begin m_run = 1; m_done = 0; end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0;
    load_value = 8'd0; limit = 8'd9; step = 8'd3; start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 9);

    // Directed vector table
    // WRAP up, limit 9, step 3 from reset
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 3,0,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 6,0,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 9,0,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 2,1,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 5,0,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 8,0,0,0));
    tbl.push_back(mk(0,0,9,3,1,0,1,0, 1,1,0,0));
    // WRAP down, limit 9, step 4 from 1
    tbl.push_back(mk(1,1,9,4,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,9,4,0,0,1,0, 7,1,0,0));
    tbl.push_back(mk(0,0,9,4,0,0,1,0, 3,0,0,0));
    tbl.push_back(mk(0,0,9,4,0,0,1,0, 9,1,0,0));
    // SATURATE up, limit 200, step 50 from 120
    tbl.push_back(mk(1,120,200,50,1,1,0,0, 120,0,0,0));
    tbl.push_back(mk(0,0,200,50,1,1,1,0, 170,0,0,0));
    tbl.push_back(mk(0,0,200,50,1,1,1,0, 200,0,0,0));
    tbl.push_back(mk(0,0,200,50,1,1,1,0, 200,0,0,0));
    // ONE_SHOT up, limit 5, step 1 from 2
    tbl.push_back(mk(1,2,5,1,1,2,0,0, 2,0,0,0));
    tbl.push_back(mk(0,0,5,1,1,2,1,0, 2,0,0,0));
    tbl.push_back(mk(0,0,5,1,1,2,1,1, 2,0,1,0));
    tbl.push_back(mk(0,0,5,1,1,2,1,0, 3,0,1,0));
    tbl.push_back(mk(0,0,5,1,1,2,1,0, 4,0,1,0));
    tbl.push_back(mk(0,0,5,1,1,2,1,0, 5,0,0,1));
    tbl.push_back(mk(0,0,5,1,1,2,1,0, 5,0,0,1));
    tbl.push_back(mk(1,5,5,1,1,2,0,0, 5,0,0,0));
    tbl.push_back(mk(0,0,5,1,1,2,0,1, 5,0,0,1));
    // Start ignored in RUN; load beats start and clamps to limit
    tbl.push_back(mk(1,0,100,1,1,2,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,100,1,1,2,0,1, 0,0,1,0));
    tbl.push_back(mk(0,0,100,1,1,2,1,1, 1,0,1,0));
    tbl.push_back(mk(1,250,100,1,1,2,1,1, 100,0,0,0));
    // limit 0, WRAP step 1: carry every enabled cycle
    tbl.push_back(mk(1,0,0,1,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0,0, 0,0,0,0));
    // Limit lowered below value: clamp without step or carry
    tbl.push_back(mk(1,8,9,3,1,0,0,0, 8,0,0,0));
    tbl.push_back(mk(0,0,4,3,1,0,1,0, 4,0,0,0));
    tbl.push_back(mk(0,0,4,3,1,0,1,0, 2,1,0,0));
    // HOLD mode and step 0
    tbl.push_back(mk(0,0,4,3,1,3,1,1, 2,0,0,0));
    tbl.push_back(mk(0,0,4,0,1,0,1,0, 2,0,0,0));
    // ONE_SHOT down to zero, then leaving ONE_SHOT clears done
    tbl.push_back(mk(1,2,9,1,0,2,0,0, 2,0,0,0));
    tbl.push_back(mk(0,0,9,1,0,2,0,1, 2,0,1,0));
    tbl.push_back(mk(0,0,9,1,0,2,1,0, 1,0,1,0));
    tbl.push_back(mk(0,0,9,1,0,2,1,0, 0,0,0,1));
    tbl.push_back(mk(0,0,9,1,0,0,0,0, 0,0,0,0));

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      load = tbl[i].ld; load_value = tbl[i].lv; limit = tbl[i].lim; step = tbl[i].st;
      dir = tbl[i].dr; mode = tbl[i].md; en = tbl[i].e; start = tbl[i].s;
      @(posedge clk);
      #1;
      chk_all($sformatf("tbl[%0d]", i), int'(tbl[i].ev), int'(tbl[i].ec),
              int'(tbl[i].eb), int'(tbl[i].ed), int'(tbl[i].lim));
    end

    // Asynchronous reset mid-count at value 7
    @(negedge clk);
    load = 1'b1; load_value = 8'd0; limit = 8'd20; step = 8'd1; dir = 1'b1;
    mode = 2'd0; en = 1'b0; start = 1'b0;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk_all("pre-reset", 7, 0, 0, 0, 20);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 20);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post-reset idle", 0, 0, 0, 0, 20);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post-reset count", 1, 0, 0, 0, 20);

    // Randomized run against the behavioural model
    @(negedge clk);
    reset = 1'b1;
    limit = 8'd12; step = 8'd1; mode = 2'd2; dir = 1'b1;
    en = 1'b0; load = 1'b0; start = 1'b0;
    m_v = 0; m_c = 0; m_run = 0; m_done = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int smax;
      @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        limit = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      smax = int'(limit) + 1;
      if (smax > 255) smax = 255;
      step = 8'($urandom_range(0, smax));
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  dir = ~dir;
      en         = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 24) == 0);
      load_value = 8'($urandom_range(0, 255));
      start      = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #1;
      model_edge();
      chk_all("rand", m_v, m_c, m_run, m_done, int'(limit));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_counter_universal
`default_nettype wire
